// File: rtl/power_request_sequencer.sv
// rtl/power_request_sequencer.sv - idle/wake policy driving power off/on requests to the gating controller
// Tracks idle time, runs the req/ack handshakes, latches wakes seen mid-shutdown and flags ack timeouts.
module power_request_sequencer #(
    parameter int IDLE_CYCLES = 64,
    parameter int CNT_W       = 16,
    parameter int ACK_TIMEOUT = 256,
    parameter int TO_W        = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic activity_i,
    input  logic wake_req_i,
    input  logic force_on_i,
    input  logic err_clr_i,
    input  logic power_off_ack_i,
    input  logic power_on_ack_i,
    output logic power_off_req_o,
    output logic power_on_req_o,
    output logic domain_on_o,
    output logic busy_o,
    output logic timeout_err_o
);

    typedef enum logic [1:0] {
        ST_ON      = 2'd0,
        ST_REQ_OFF = 2'd1,
        ST_OFF     = 2'd2,
        ST_REQ_ON  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(ACK_TIMEOUT - 1);

    state_e           state_q;
    logic [CNT_W-1:0] idle_cnt_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             wake_pend_q;
    logic             power_off_req_q;
    logic             power_on_req_q;
    logic             domain_on_q;
    logic             busy_q;
    logic             timeout_err_q;

    logic idle_now;
    logic to_expired;
    logic wake_any;

    assign idle_now   = !activity_i && !force_on_i;
    assign to_expired = (to_cnt_q == TO_LAST);
    assign wake_any   = wake_req_i || force_on_i;

    // err_clr is applied first so a timeout set later in the same edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_ON;
            idle_cnt_q      <= '0;
            to_cnt_q        <= '0;
            wake_pend_q     <= 1'b0;
            power_off_req_q <= 1'b0;
            power_on_req_q  <= 1'b0;
            domain_on_q     <= 1'b1;
            busy_q          <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            if (err_clr_i) begin
                timeout_err_q <= 1'b0;
            end
            case (state_q)
                ST_ON: begin
                    if (!idle_now) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        // A wake held at saturation keeps the domain up without losing the count.
                        if (!wake_req_i) begin
                            state_q         <= ST_REQ_OFF;
                            power_off_req_q <= 1'b1;
                            busy_q          <= 1'b1;
                            to_cnt_q        <= '0;
                            wake_pend_q     <= 1'b0;
                        end
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                ST_REQ_OFF: begin
                    if (wake_any) begin
                        wake_pend_q <= 1'b1;
                    end
                    if (power_off_ack_i) begin
                        state_q         <= ST_OFF;
                        power_off_req_q <= 1'b0;
                        domain_on_q     <= 1'b0;
                        busy_q          <= 1'b0;
                        to_cnt_q        <= '0;
                    end else if (to_expired) begin
                        state_q         <= ST_ON;
                        power_off_req_q <= 1'b0;
                        busy_q          <= 1'b0;
                        timeout_err_q   <= 1'b1;
                        idle_cnt_q      <= '0;
                        to_cnt_q        <= '0;
                        wake_pend_q     <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_OFF: begin
                    if (wake_any || wake_pend_q) begin
                        state_q        <= ST_REQ_ON;
                        power_on_req_q <= 1'b1;
                        busy_q         <= 1'b1;
                        to_cnt_q       <= '0;
                        wake_pend_q    <= 1'b0;
                    end
                end
                ST_REQ_ON: begin
                    if (power_on_ack_i) begin
                        state_q        <= ST_ON;
                        power_on_req_q <= 1'b0;
                        domain_on_q    <= 1'b1;
                        busy_q         <= 1'b0;
                        idle_cnt_q     <= '0;
                        to_cnt_q       <= '0;
                    end else if (to_expired) begin
                        // The domain must come back, so keep requesting and only report.
                        timeout_err_q <= 1'b1;
                        to_cnt_q      <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q         <= ST_ON;
                    power_off_req_q <= 1'b0;
                    power_on_req_q  <= 1'b0;
                    domain_on_q     <= 1'b1;
                    busy_q          <= 1'b0;
                end
            endcase
        end
    end

    assign power_off_req_o = power_off_req_q;
    assign power_on_req_o  = power_on_req_q;
    assign domain_on_o     = domain_on_q;
    assign busy_o          = busy_q;
    assign timeout_err_o   = timeout_err_q;

endmodule

// File: tb/tb_power_request_sequencer.sv
// tb/tb_power_request_sequencer.sv - directed self-checking bench for power_request_sequencer
module tb_power_request_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic activity = 1'b0;
    logic wake_req = 1'b0;
    logic force_on = 1'b0;
    logic err_clr = 1'b0;
    logic power_off_ack = 1'b0;
    logic power_on_ack = 1'b0;
    logic power_off_req;
    logic power_on_req;
    logic domain_on;
    logic busy;
    logic timeout_err;

    int checks = 0;
    int errors = 0;

    power_request_sequencer #(
        .IDLE_CYCLES(64),
        .CNT_W(16),
        .ACK_TIMEOUT(256),
        .TO_W(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .activity_i(activity),
        .wake_req_i(wake_req),
        .force_on_i(force_on),
        .err_clr_i(err_clr),
        .power_off_ack_i(power_off_ack),
        .power_on_ack_i(power_on_ack),
        .power_off_req_o(power_off_req),
        .power_on_req_o(power_on_req),
        .domain_on_o(domain_on),
        .busy_o(busy),
        .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic off_r, input logic on_r,
                            input logic dom, input logic bsy, input logic err);
        chk({tag, ".off_req"}, power_off_req, off_r);
        chk({tag, ".on_req"}, power_on_req, on_r);
        chk({tag, ".domain_on"}, domain_on, dom);
        chk({tag, ".busy"}, busy, bsy);
        chk({tag, ".timeout_err"}, timeout_err, err);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(power_off_req && power_on_req)) else begin
                errors++;
                $error("FAIL req_mutex: observed off=%b on=%b expected not both", power_off_req, power_on_req);
            end
        end
    end

    initial begin
        tick(3);
        chk_outs("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        // Idle count restarted by activity in idle cycle 63, then a full 64-cycle run.
        tick(62);
        activity = 1'b1;
        tick(1);
        activity = 1'b0;
        chk_outs("act_restart", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(63);
        chk_outs("idle63", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_outs("idle64", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Off ack after 10 cycles, activity ignored in OFF, wake, on ack.
        tick(9);
        chk("req_off_hold", power_off_req, 1'b1);
        power_off_ack = 1'b1;
        tick(1);
        power_off_ack = 1'b0;
        chk_outs("off_acked", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        activity = 1'b1;
        tick(3);
        activity = 1'b0;
        chk_outs("off_stays", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wake_req = 1'b1;
        tick(1);
        wake_req = 1'b0;
        chk_outs("wake_to_req_on", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        power_on_ack = 1'b1;
        tick(1);
        power_on_ack = 1'b0;
        chk_outs("on_acked", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(63);
        chk("idle_restart63", power_off_req, 1'b0);
        tick(1);
        chk("idle_restart64", power_off_req, 1'b1);

        // Wrong-channel ack in REQ_OFF, then a wake latched during the handshake.
        power_on_ack = 1'b1;
        tick(1);
        power_on_ack = 1'b0;
        chk_outs("wrong_ack_req_off", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        wake_req = 1'b1;
        tick(1);
        wake_req = 1'b0;
        chk("wake_no_abort", power_off_req, 1'b1);
        power_off_ack = 1'b1;
        tick(1);
        power_off_ack = 1'b0;
        chk_outs("brief_off", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_outs("pend_req_on", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Wrong-channel ack in REQ_ON, then REQ_ON timeout keeps requesting.
        power_off_ack = 1'b1;
        tick(1);
        power_off_ack = 1'b0;
        chk_outs("wrong_ack_req_on", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(254);
        chk("req_on_pre_to", timeout_err, 1'b0);
        tick(1);
        chk_outs("req_on_timeout", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clr", timeout_err, 1'b0);
        power_on_ack = 1'b1;
        tick(1);
        power_on_ack = 1'b0;
        chk_outs("late_on_ack", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // REQ_OFF timeout returns to ON and restarts the idle count.
        tick(64);
        chk("req_off_again", power_off_req, 1'b1);
        tick(255);
        chk_outs("req_off_pre_to", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_outs("req_off_timeout", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(63);
        chk("to_idle_restart63", power_off_req, 1'b0);
        tick(1);
        chk("to_idle_restart64", power_off_req, 1'b1);

        // Timeout set wins over err_clr in the same cycle.
        tick(255);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk_outs("set_wins", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // force_on blocks the off request; spurious acks in ON are ignored.
        force_on = 1'b1;
        tick(1000);
        chk_outs("force_on_1000", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        force_on = 1'b0;
        power_on_ack = 1'b1;
        power_off_ack = 1'b1;
        tick(1);
        power_on_ack = 1'b0;
        power_off_ack = 1'b0;
        chk_outs("spurious_ack_on", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset mid REQ_OFF drops the request before the next edge.
        tick(63);
        chk("pre_rst_req", power_off_req, 1'b1);
        tick(3);
        #2 rst = 1'b1;
        #1;
        chk_outs("async_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        chk_outs("post_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
